// File: rtl/score_ctrl_if.sv
// Score controller bus: debounced game inputs and registered
// score, serve, sound and status outputs.
interface score_ctrl_if;
  logic       start;
  logic       pt_left;
  logic       pt_right;
  logic [7:0] score_left;
  logic [7:0] score_right;
  logic       serve_en;
  logic       snd_point;
  logic       snd_lose;
  logic [1:0] winner;
  logic [1:0] state;

  modport master (
    output start, pt_left, pt_right,
    input  score_left, score_right, serve_en,
    input  snd_point, snd_lose, winner, state
  );

  modport slave (
    input  start, pt_left, pt_right,
    output score_left, score_right, serve_en,
    output snd_point, snd_lose, winner, state
  );
endinterface

// File: rtl/score_ctrl.sv
// Pong-style score controller: BCD scores, serve delay, win
// detection and sound-event pulses.
module score_ctrl #(
  parameter logic [7:0] WIN_SCORE   = 8'h11,
  parameter int         HOLD_CYCLES = 25000000
) (
  input  logic         clk,
  input  logic         reset,
  score_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    HOLD = 2'b10,
    OVER = 2'b11
  } state_t;

  localparam int TW = $clog2(HOLD_CYCLES);
  localparam logic [TW-1:0] RELOAD = TW'(HOLD_CYCLES - 1);

  state_t        r_state, w_state_n;
  logic [TW-1:0] r_timer, w_timer_n;
  logic [7:0]    r_sl, w_sl_n;
  logic [7:0]    r_sr, w_sr_n;
  logic [1:0]    r_win, w_win_n;
  logic          r_prio, w_prio_n;
  logic          r_serve;
  logic          r_snd_pt, w_snd_pt_n;
  logic          r_snd_lose, w_snd_lose_n;
  logic          w_left_pt, w_right_pt;
  logic [7:0]    w_new;

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [7:0] r;
    if (s == 8'h99)
      r = s;
    else if (s[3:0] == 4'd9)
      r = {s[7:4] + 4'd1, 4'd0};
    else
      r = {s[7:4], s[3:0] + 4'd1};
    return r;
  endfunction

  // r_prio low means a simultaneous pair goes to the left side
  assign w_left_pt  = bus.pt_left &
                      (~bus.pt_right | ~r_prio);
  assign w_right_pt = bus.pt_right &
                      (~bus.pt_left | r_prio);
  assign w_new = w_left_pt ? bcd_inc(r_sl)
                           : bcd_inc(r_sr);

  always_comb begin
    w_state_n    = r_state;
    w_timer_n    = r_timer;
    w_sl_n       = r_sl;
    w_sr_n       = r_sr;
    w_win_n      = r_win;
    w_prio_n     = r_prio;
    w_snd_pt_n   = 1'b0;
    w_snd_lose_n = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_n = HOLD;
          w_timer_n = RELOAD;
        end
      end
      HOLD: begin
        if (r_timer == '0)
          w_state_n = PLAY;
        else
          w_timer_n = r_timer - 1'b1;
      end
      PLAY: begin
        if (w_left_pt || w_right_pt) begin
          if (bus.pt_left && bus.pt_right)
            w_prio_n = ~r_prio;
          if (w_left_pt)
            w_sl_n = w_new;
          else
            w_sr_n = w_new;
          if (w_new == WIN_SCORE) begin
            w_state_n    = OVER;
            w_win_n      = w_left_pt ? 2'b01 : 2'b10;
            w_snd_lose_n = 1'b1;
          end else begin
            w_state_n  = HOLD;
            w_timer_n  = RELOAD;
            w_snd_pt_n = 1'b1;
          end
        end
      end
      OVER: begin
        if (bus.start) begin
          w_state_n = HOLD;
          w_timer_n = RELOAD;
          w_sl_n    = 8'h00;
          w_sr_n    = 8'h00;
          w_win_n   = 2'b00;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_sl       <= 8'h00;
      r_sr       <= 8'h00;
      r_win      <= 2'b00;
      r_prio     <= 1'b0;
      r_serve    <= 1'b0;
      r_snd_pt   <= 1'b0;
      r_snd_lose <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_timer    <= w_timer_n;
      r_sl       <= w_sl_n;
      r_sr       <= w_sr_n;
      r_win      <= w_win_n;
      r_prio     <= w_prio_n;
      r_serve    <= (w_state_n == PLAY);
      r_snd_pt   <= w_snd_pt_n;
      r_snd_lose <= w_snd_lose_n;
    end
  end

  assign bus.score_left  = r_sl;
  assign bus.score_right = r_sr;
  assign bus.serve_en    = r_serve;
  assign bus.snd_point   = r_snd_pt;
  assign bus.snd_lose    = r_snd_lose;
  assign bus.winner      = r_win;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl: one instance with a short game,
// one racing the right score to 99 for BCD carry coverage.
module tb_score_ctrl;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  score_ctrl_if ia ();
  score_ctrl_if ib ();

  score_ctrl #(
    .WIN_SCORE   (8'h03),
    .HOLD_CYCLES (4)
  ) u_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ia.slave)
  );

  score_ctrl #(
    .WIN_SCORE   (8'h99),
    .HOLD_CYCLES (4)
  ) u_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ib.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // 0 left, 1 right, 2 both, 3 start
  task automatic pulse_a(input int which);
    ia.pt_left  = (which == 0) || (which == 2);
    ia.pt_right = (which == 1) || (which == 2);
    ia.start    = (which == 3);
    tick();
    ia.pt_left  = 1'b0;
    ia.pt_right = 1'b0;
    ia.start    = 1'b0;
  endtask

  task automatic wait_a();
    for (int i = 0; i < 20; i++) begin
      if (ia.serve_en) break;
      tick();
    end
    chk("a_play_timeout", 32'(ia.serve_en), 32'd1);
  endtask

  task automatic wait_b();
    for (int i = 0; i < 20; i++) begin
      if (ib.serve_en) break;
      tick();
    end
    chk("b_play_timeout", 32'(ib.serve_en), 32'd1);
  endtask

  task automatic chk_a_reset(input string tag);
    chk({tag, "_state"}, 32'(ia.state), 32'd0);
    chk({tag, "_sl"}, 32'(ia.score_left), 32'h0);
    chk({tag, "_sr"}, 32'(ia.score_right), 32'h0);
    chk({tag, "_win"}, 32'(ia.winner), 32'd0);
    chk({tag, "_serve"}, 32'(ia.serve_en), 32'd0);
    chk({tag, "_sndp"}, 32'(ia.snd_point), 32'd0);
    chk({tag, "_sndl"}, 32'(ia.snd_lose), 32'd0);
  endtask

  logic [7:0] e;

  initial begin
    ia.start = 1'b0; ia.pt_left = 1'b0; ia.pt_right = 1'b0;
    ib.start = 1'b0; ib.pt_left = 1'b0; ib.pt_right = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) tick();
    chk_a_reset("rst");
    rst_a = 1'b0;
    tick();

    // start -> HOLD, PLAY 5 cycles after the start pulse
    pulse_a(3);
    chk("start_state", 32'(ia.state), 32'd2);
    chk("start_serve", 32'(ia.serve_en), 32'd0);
    repeat (3) tick();
    chk("hold4_state", 32'(ia.state), 32'd2);
    chk("hold4_serve", 32'(ia.serve_en), 32'd0);
    tick();
    chk("play_state", 32'(ia.state), 32'd1);
    chk("play_serve", 32'(ia.serve_en), 32'd1);

    // first point
    pulse_a(0);
    chk("p1_sl", 32'(ia.score_left), 32'h01);
    chk("p1_sndp", 32'(ia.snd_point), 32'd1);
    chk("p1_sndl", 32'(ia.snd_lose), 32'd0);
    chk("p1_state", 32'(ia.state), 32'd2);
    chk("p1_serve", 32'(ia.serve_en), 32'd0);
    tick();
    chk("p1_sndp_off", 32'(ia.snd_point), 32'd0);

    wait_a();
    pulse_a(0);
    chk("p2_sl", 32'(ia.score_left), 32'h02);
    wait_a();
    pulse_a(0);
    chk("win_sl", 32'(ia.score_left), 32'h03);
    chk("win_winner", 32'(ia.winner), 32'd1);
    chk("win_sndl", 32'(ia.snd_lose), 32'd1);
    chk("win_sndp", 32'(ia.snd_point), 32'd0);
    chk("win_state", 32'(ia.state), 32'd3);
    tick();
    chk("win_sndl_off", 32'(ia.snd_lose), 32'd0);

    // OVER ignores points, start restarts
    pulse_a(1);
    chk("over_sr", 32'(ia.score_right), 32'h00);
    chk("over_sl", 32'(ia.score_left), 32'h03);
    chk("over_state", 32'(ia.state), 32'd3);
    pulse_a(3);
    chk("rs_sl", 32'(ia.score_left), 32'h00);
    chk("rs_sr", 32'(ia.score_right), 32'h00);
    chk("rs_win", 32'(ia.winner), 32'd0);
    chk("rs_state", 32'(ia.state), 32'd2);
    chk("rs_sndp", 32'(ia.snd_point), 32'd0);

    // simultaneous points alternate, left first
    wait_a();
    pulse_a(2);
    chk("tie1_sl", 32'(ia.score_left), 32'h01);
    chk("tie1_sr", 32'(ia.score_right), 32'h00);
    wait_a();
    pulse_a(2);
    chk("tie2_sl", 32'(ia.score_left), 32'h01);
    chk("tie2_sr", 32'(ia.score_right), 32'h01);

    // held pt awards a single point
    wait_a();
    ia.pt_left = 1'b1;
    repeat (3) tick();
    ia.pt_left = 1'b0;
    chk("held_sl", 32'(ia.score_left), 32'h02);
    chk("held_state", 32'(ia.state), 32'd2);

    // async reset mid-HOLD with a coincident point
    #1;
    ia.pt_right = 1'b1;
    rst_a = 1'b1;
    #1;
    chk_a_reset("arst");
    tick();
    chk("arst_pt_sr", 32'(ia.score_right), 32'h00);
    ia.pt_right = 1'b0;
    rst_a = 1'b0;
    tick();
    pulse_a(3);
    chk("after_rst_state", 32'(ia.state), 32'd2);
    chk("after_rst_sl", 32'(ia.score_left), 32'h00);
    chk("after_rst_sr", 32'(ia.score_right), 32'h00);

    // instance B: right side counts 1..99 in BCD
    rst_b = 1'b0;
    tick();
    ib.start = 1'b1;
    tick();
    ib.start = 1'b0;
    for (int n = 1; n <= 99; n++) begin
      wait_b();
      ib.pt_right = 1'b1;
      tick();
      ib.pt_right = 1'b0;
      e = {4'(n / 10), 4'(n % 10)};
      chk($sformatf("b_sr_%0d", n), 32'(ib.score_right), 32'(e));
    end
    chk("b_state", 32'(ib.state), 32'd3);
    chk("b_winner", 32'(ib.winner), 32'd2);
    chk("b_sndl", 32'(ib.snd_lose), 32'd1);
    chk("b_sl", 32'(ib.score_left), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
